// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
//   Shared types and constants for the stopwatch lap core.
//   - sw_state_e : run-control states (IDLE, RUNNING, PAUSED)
//   - SEC_MAX / MS_MAX : roll-over points of the seconds and millisecond fields
//   - SEC_W / MS_W : widths of the seconds and millisecond fields
//   - MIN_FIELD_W : container width for minutes inside a stored lap entry
//   - time_t : one {min, sec, ms} time value as kept in the lap buffer
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_e;

    localparam int SEC_MAX = 59;
    localparam int MS_MAX  = 999;

    localparam int SEC_W = 6;
    localparam int MS_W  = 10;

    // Minutes container inside a lap entry. The live minutes field is
    // $clog2(MIN_MAX+1) wide and is zero-extended into this container, so
    // MIN_MAX may be anything up to 127.
    localparam int MIN_FIELD_W = 7;

    typedef struct packed {
        logic [MIN_FIELD_W-1:0] min;
        logic [SEC_W-1:0]       sec;
        logic [MS_W-1:0]        ms;
    } time_t;

endpackage

// File: rtl/sw_lap_buffer.sv
// -----------------------------------------------------------------------------
// sw_lap_buffer
//   LAP_DEPTH-entry store of captured lap times. Entries are filled in order
//   (entry index == number of laps already stored); once full, further writes
//   are dropped. The readout register loads entry rd_sel every cycle; entries
//   at or above the stored count read as zero.
//
// Ports
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : synchronous clear of all entries, the count and the readout
//   wr_en      : capture request; honoured only while not full
//   wr_data    : time value to store
//   rd_sel     : entry to present on rd_data
//   rd_data    : registered readout of entry rd_sel
//   count      : number of stored entries
//   full       : count == LAP_DEPTH
//
// Handshake: wr_en is a single-cycle strobe with no back-pressure; a strobe
// that arrives while full is silently discarded.
// -----------------------------------------------------------------------------
module sw_lap_buffer
    import stopwatch_pkg::*;
#(
    parameter  int LAP_DEPTH = 4,
    localparam int IDX_W     = $clog2(LAP_DEPTH),
    localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_en,
    input  time_t            wr_data,
    input  logic [IDX_W-1:0] rd_sel,
    output time_t            rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    time_t            mem_q [LAP_DEPTH];
    time_t            mem_d [LAP_DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    time_t            rd_q;
    time_t            rd_d;
    logic             full_w;

    assign full_w = (count_q == CNT_W'(LAP_DEPTH));

    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        rd_d    = '0;

        // Readout sees the array before any write in this cycle, so a freshly
        // written entry shows up one edge after its write.
        if (CNT_W'(rd_sel) < count_q) begin
            rd_d = mem_q[rd_sel];
        end

        if (clear) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_d[i] = '0;
            end
            count_d = '0;
            rd_d    = '0;
        end else if (wr_en && !full_w) begin
            // Not full means count_q < LAP_DEPTH, so its low bits index
            // the next free entry (LAP_DEPTH is a power of two).
            mem_d[count_q[IDX_W-1:0]] = wr_data;
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            rd_q    <= '0;
        end else begin
            for (int i = 0; i < LAP_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            count_q <= count_d;
            rd_q    <= rd_d;
        end
    end

    assign rd_data = rd_q;
    assign count   = count_q;
    assign full    = full_w;

endmodule

// File: rtl/stopwatch_lap_core.sv
// -----------------------------------------------------------------------------
// stopwatch_lap_core
//   Minutes:seconds:milliseconds stopwatch with lap capture. A prescaler
//   running on the system clock produces a one-cycle millisecond tick while
//   RUNNING; the tick advances a ms -> sec -> min cascade. At full scale
//   (MIN_MAX:59.999) the count either rolls over to zero (WRAP=1) or holds
//   and pauses (WRAP=0); both set the sticky overflow flag.
//
// Parameters
//   TICK_DIV  : system clocks per millisecond tick (>= 2)
//   MIN_MAX   : highest minutes value (<= 127)
//   LAP_DEPTH : lap buffer entries (power of two, >= 2)
//   WRAP      : 1 = roll over at full scale, 0 = saturate and pause
//
// Ports
//   clk, reset               : system clock, asynchronous active-high reset
//   start_stop, clear, lap   : debounced levels; each acts on its rising edge
//   lap_sel                  : lap entry to read out
//   minutes/seconds/milliseconds : live time
//   running                  : 1 while RUNNING
//   overflow                 : sticky, full scale was passed
//   lap_count, lap_full      : lap buffer fill level
//   lap_min/lap_sec/lap_ms   : registered readout of entry lap_sel
//
// Button handling: every input has a previous-value register that resets to
// 1, so a button held through reset does not produce an edge until it is
// released and pressed again. Within one cycle clear wins over start_stop,
// which wins over lap; all decisions use the state before the edge.
// -----------------------------------------------------------------------------
module stopwatch_lap_core
    import stopwatch_pkg::*;
#(
    parameter  int TICK_DIV  = 100000,
    parameter  int MIN_MAX   = 99,
    parameter  int LAP_DEPTH = 4,
    parameter  int WRAP      = 1,
    localparam int MIN_W     = $clog2(MIN_MAX + 1),
    localparam int SEL_W     = $clog2(LAP_DEPTH),
    localparam int CNT_W     = $clog2(LAP_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic             lap,
    input  logic [SEL_W-1:0] lap_sel,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic [MS_W-1:0]  milliseconds,
    output logic             running,
    output logic             overflow,
    output logic [CNT_W-1:0] lap_count,
    output logic             lap_full,
    output logic [MIN_W-1:0] lap_min,
    output logic [SEC_W-1:0] lap_sec,
    output logic [MS_W-1:0]  lap_ms
);

    localparam int PRE_W = $clog2(TICK_DIV);

    // Edge detectors
    logic ss_prev_q;
    logic clr_prev_q;
    logic lap_prev_q;
    logic ss_edge;
    logic clr_edge;
    logic lap_edge;

    // Run control and counters
    sw_state_e        state_q;
    sw_state_e        state_d;
    logic [PRE_W-1:0] presc_q;
    logic [PRE_W-1:0] presc_d;
    logic [MIN_W-1:0] min_q;
    logic [MIN_W-1:0] min_d;
    logic [SEC_W-1:0] sec_q;
    logic [SEC_W-1:0] sec_d;
    logic [MS_W-1:0]  ms_q;
    logic [MS_W-1:0]  ms_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             running_q;
    logic             running_d;

    logic             tick;
    logic             full_scale;
    logic             lap_wr;
    time_t            lap_wr_data;
    time_t            lap_rd_data;

    assign ss_edge  = start_stop & ~ss_prev_q;
    assign clr_edge = clear      & ~clr_prev_q;
    assign lap_edge = lap        & ~lap_prev_q;

    assign tick       = (state_q == RUNNING) && (presc_q == PRE_W'(TICK_DIV - 1));
    assign full_scale = (min_q == MIN_W'(MIN_MAX)) &&
                        (sec_q == SEC_W'(SEC_MAX)) &&
                        (ms_q  == MS_W'(MS_MAX));

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        min_d      = min_q;
        sec_d      = sec_q;
        ms_d       = ms_q;
        overflow_d = overflow_q;
        lap_wr     = 1'b0;

        if (clr_edge) begin
            // Clear swallows any tick, toggle or lap arriving with it.
            state_d    = IDLE;
            presc_d    = '0;
            min_d      = '0;
            sec_d      = '0;
            ms_d       = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    presc_d = '0;
                    if (ss_edge) state_d = RUNNING;
                end
                RUNNING: begin
                    // Counting continues on the pausing edge: the prescaler
                    // and the tick both follow the pre-edge state.
                    presc_d = tick ? '0 : presc_q + PRE_W'(1);
                    if (ss_edge) state_d = PAUSED;
                end
                PAUSED: begin
                    // Prescaler holds, keeping the sub-millisecond fraction.
                    if (ss_edge) state_d = RUNNING;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (tick) begin
                if (full_scale) begin
                    overflow_d = 1'b1;
                    if (WRAP != 0) begin
                        min_d = '0;
                        sec_d = '0;
                        ms_d  = '0;
                    end else begin
                        state_d = PAUSED;
                    end
                end else if (ms_q == MS_W'(MS_MAX)) begin
                    ms_d = '0;
                    if (sec_q == SEC_W'(SEC_MAX)) begin
                        sec_d = '0;
                        min_d = min_q + MIN_W'(1);
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end else begin
                    ms_d = ms_q + MS_W'(1);
                end
            end

            // Captures the pre-tick time; the buffer itself drops the
            // request when already full.
            lap_wr = lap_edge && (state_q == RUNNING);
        end

        running_d = (state_d == RUNNING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_prev_q  <= 1'b1;
            clr_prev_q <= 1'b1;
            lap_prev_q <= 1'b1;
            state_q    <= IDLE;
            presc_q    <= '0;
            min_q      <= '0;
            sec_q      <= '0;
            ms_q       <= '0;
            overflow_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            ss_prev_q  <= start_stop;
            clr_prev_q <= clear;
            lap_prev_q <= lap;
            state_q    <= state_d;
            presc_q    <= presc_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            ms_q       <= ms_d;
            overflow_q <= overflow_d;
            running_q  <= running_d;
        end
    end

    always_comb begin
        lap_wr_data     = '0;
        lap_wr_data.min = MIN_FIELD_W'(min_q);
        lap_wr_data.sec = sec_q;
        lap_wr_data.ms  = ms_q;
    end

    sw_lap_buffer #(
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_buffer (
        .clk     (clk),
        .reset   (reset),
        .clear   (clr_edge),
        .wr_en   (lap_wr),
        .wr_data (lap_wr_data),
        .rd_sel  (lap_sel),
        .rd_data (lap_rd_data),
        .count   (lap_count),
        .full    (lap_full)
    );

    assign minutes      = min_q;
    assign seconds      = sec_q;
    assign milliseconds = ms_q;
    assign running      = running_q;
    assign overflow     = overflow_q;
    assign lap_min      = lap_rd_data.min[MIN_W-1:0];
    assign lap_sec      = lap_rd_data.sec;
    assign lap_ms       = lap_rd_data.ms;

endmodule

// File: tb/tb_stopwatch_lap_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_lap_core
//   Directed bench. dut_a (TICK_DIV=4, MIN_MAX=99, LAP_DEPTH=4, WRAP=1) covers
//   run/pause, prescaler phase, laps, clear priority and reset. dut_b (WRAP=1)
//   and dut_c (WRAP=0), both MIN_MAX=1, share inputs and cover full scale.
//   Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stopwatch_lap_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // dut_a
    logic       a_reset, a_ss, a_clr, a_lap;
    logic [1:0] a_sel;
    logic [6:0] a_min, a_lmin;
    logic [5:0] a_sec, a_lsec;
    logic [9:0] a_ms, a_lms;
    logic       a_run, a_ovf, a_full;
    logic [2:0] a_cnt;

    // dut_b / dut_c shared inputs
    logic       w_reset, w_ss, w_clr, w_lap;
    logic [1:0] w_sel;
    logic       b_min, b_lmin, c_min, c_lmin;
    logic [5:0] b_sec, b_lsec, c_sec, c_lsec;
    logic [9:0] b_ms, b_lms, c_ms, c_lms;
    logic       b_run, b_ovf, b_full, c_run, c_ovf, c_full;
    logic [2:0] b_cnt, c_cnt;

    stopwatch_lap_core #(.TICK_DIV(4), .MIN_MAX(99), .LAP_DEPTH(4), .WRAP(1)) dut_a (
        .clk(clk), .reset(a_reset), .start_stop(a_ss), .clear(a_clr), .lap(a_lap),
        .lap_sel(a_sel), .minutes(a_min), .seconds(a_sec), .milliseconds(a_ms),
        .running(a_run), .overflow(a_ovf), .lap_count(a_cnt), .lap_full(a_full),
        .lap_min(a_lmin), .lap_sec(a_lsec), .lap_ms(a_lms)
    );

    stopwatch_lap_core #(.TICK_DIV(4), .MIN_MAX(1), .LAP_DEPTH(4), .WRAP(1)) dut_b (
        .clk(clk), .reset(w_reset), .start_stop(w_ss), .clear(w_clr), .lap(w_lap),
        .lap_sel(w_sel), .minutes(b_min), .seconds(b_sec), .milliseconds(b_ms),
        .running(b_run), .overflow(b_ovf), .lap_count(b_cnt), .lap_full(b_full),
        .lap_min(b_lmin), .lap_sec(b_lsec), .lap_ms(b_lms)
    );

    stopwatch_lap_core #(.TICK_DIV(4), .MIN_MAX(1), .LAP_DEPTH(4), .WRAP(0)) dut_c (
        .clk(clk), .reset(w_reset), .start_stop(w_ss), .clear(w_clr), .lap(w_lap),
        .lap_sel(w_sel), .minutes(c_min), .seconds(c_sec), .milliseconds(c_ms),
        .running(c_run), .overflow(c_ovf), .lap_count(c_cnt), .lap_full(c_full),
        .lap_min(c_lmin), .lap_sec(c_lsec), .lap_ms(c_lms)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        a_reset = 1'b1; a_ss = 1'b0; a_clr = 1'b0; a_lap = 1'b0; a_sel = 2'd0;
        w_reset = 1'b1; w_ss = 1'b0; w_clr = 1'b0; w_lap = 1'b0; w_sel = 2'd0;

        // ---- reset values
        step(3);
        check("rst_ms",   a_ms,   0);
        check("rst_sec",  a_sec,  0);
        check("rst_min",  a_min,  0);
        check("rst_run",  a_run,  0);
        check("rst_ovf",  a_ovf,  0);
        check("rst_cnt",  a_cnt,  0);
        check("rst_full", a_full, 0);
        check("rst_lms",  a_lms,  0);
        a_reset = 1'b0; w_reset = 1'b0;
        step(2);

        // ---- run 4000 clocks -> 00:01.000, then pause
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        check("start_run", a_run, 1);
        step(3999);
        check("t0999_ms",  a_ms,  999);
        check("t0999_sec", a_sec, 0);
        step(1);
        check("t1000_ms",  a_ms,  0);
        check("t1000_sec", a_sec, 1);
        check("t1000_min", a_min, 0);
        check("t1000_run", a_run, 1);
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        check("pause_run", a_run, 0);
        step(100);
        check("paused_ms",  a_ms,  0);
        check("paused_sec", a_sec, 1);
        check("paused_run", a_run, 0);

        // ---- clear, then pause with prescaler at phase 2 and resume
        a_clr = 1'b1; step(1); a_clr = 1'b0;
        check("clr_sec", a_sec, 0);
        check("clr_run", a_run, 0);
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        step(1);
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        step(5);
        check("ph2_paused_ms",  a_ms,  0);
        check("ph2_paused_run", a_run, 0);
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        check("resume_run", a_run, 1);
        check("resume_ms",  a_ms,  0);
        step(1);
        check("resume_p1_ms", a_ms, 0);
        step(1);
        check("resume_p2_ms", a_ms, 1);

        // ---- five laps at 10..50 ms
        a_clr = 1'b1; step(1); a_clr = 1'b0;
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        step(40);
        for (int i = 0; i < 5; i++) begin
            a_lap = 1'b1; step(1); a_lap = 1'b0;
            check($sformatf("lap%0d_cnt", i), a_cnt, (i < 4) ? i + 1 : 4);
            step(39);
        end
        check("laps_full", a_full, 1);
        for (int i = 0; i < 4; i++) begin
            a_sel = 2'(i); step(1);
            check($sformatf("lap%0d_ms", i),  a_lms,  (i + 1) * 10);
            check($sformatf("lap%0d_sec", i), a_lsec, 0);
            check($sformatf("lap%0d_min", i), a_lmin, 0);
        end

        // ---- lap on the tick 004 -> 005 stores 004
        a_clr = 1'b1; step(1); a_clr = 1'b0;
        check("clr_cnt",  a_cnt,  0);
        check("clr_full", a_full, 0);
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        step(19);
        a_lap = 1'b1; a_sel = 2'd0; step(1); a_lap = 1'b0;
        check("laptick_live_ms", a_ms,  5);
        check("laptick_cnt",     a_cnt, 1);
        step(1);
        check("laptick_lap_ms", a_lms, 4);
        a_sel = 2'd1; step(1);
        check("above_cnt_ms", a_lms, 0);
        a_sel = 2'd0; step(1);

        // ---- clear + start_stop + lap on the same edge
        a_clr = 1'b1; a_ss = 1'b1; a_lap = 1'b1; step(1);
        check("cslap_run", a_run, 0);
        check("cslap_ms",  a_ms,  0);
        check("cslap_cnt", a_cnt, 0);
        check("cslap_lms", a_lms, 0);
        a_clr = 1'b0; a_ss = 1'b0; a_lap = 1'b0;
        step(8);
        check("cslap_idle_ms",  a_ms,  0);
        check("cslap_idle_run", a_run, 0);

        // ---- reset mid-run at 00:03.217 with the button held
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        step(12868);
        check("mid_sec", a_sec, 3);
        check("mid_ms",  a_ms,  217);
        a_ss = 1'b1; a_reset = 1'b1;
        #1;
        check("async_rst_ms",  a_ms,  0);
        check("async_rst_sec", a_sec, 0);
        check("async_rst_run", a_run, 0);
        step(2);
        a_reset = 1'b0;
        step(4);
        check("held_no_edge_run", a_run, 0);
        check("held_no_edge_ms",  a_ms,  0);
        a_ss = 1'b0; step(1);
        a_ss = 1'b1; step(1); a_ss = 1'b0;
        check("repress_run", a_run, 1);

        // ---- full scale, MIN_MAX=1: wrap (dut_b) and saturate (dut_c)
        w_ss = 1'b1; step(1); w_ss = 1'b0;
        force dut_b.min_q = 1'b1;
        force dut_b.sec_q = 6'd59;
        force dut_b.ms_q  = 10'd999;
        force dut_c.min_q = 1'b1;
        force dut_c.sec_q = 6'd59;
        force dut_c.ms_q  = 10'd999;
        #1;
        release dut_b.min_q;
        release dut_b.sec_q;
        release dut_b.ms_q;
        release dut_c.min_q;
        release dut_c.sec_q;
        release dut_c.ms_q;
        step(3);
        check("pre_wrap_ms",  b_ms,  999);
        check("pre_wrap_ovf", b_ovf, 0);
        step(1);
        check("wrap_min", b_min, 0);
        check("wrap_sec", b_sec, 0);
        check("wrap_ms",  b_ms,  0);
        check("wrap_ovf", b_ovf, 1);
        check("wrap_run", b_run, 1);
        check("sat_min",  c_min, 1);
        check("sat_sec",  c_sec, 59);
        check("sat_ms",   c_ms,  999);
        check("sat_ovf",  c_ovf, 1);
        check("sat_run",  c_run, 0);
        step(4);
        check("wrap_next_ms", b_ms,  1);
        check("sat_hold_ms",  c_ms,  999);
        check("sat_hold_run", c_run, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
